// File: rtl/fetch_align_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_align_unit
// Purpose  : Fetch/align stage behind the instruction memory. Requests one
//            64-bit line per FETCH cycle, splits it into two 32-bit slots,
//            skips empty slots, and hands one instruction at a time to decode
//            over a valid/ready handshake. Supports redirects and halts after
//            HALT_LINES consecutive all-empty lines.
// Ports    :
//   clk            - clock, rising edge
//   reset          - synchronous, active-high
//   line_idx       - [4:0]  line index to instruction memory
//   ir_line        - [63:0] line from memory (slot 0 = [63:32], slot 1 = [31:0])
//   out_valid      - instruction present on out_*
//   out_ready      - decode accepts when out_valid && out_ready
//   out_instr      - [31:0] instruction (compressed forms zero-extended)
//   out_is_c       - 1 = compressed instruction
//   out_pc         - [5:0]  {line, slot} of presented instruction
//   redirect_valid - restart fetch at redirect_line/redirect_slot
//   redirect_line  - [4:0]  target line
//   redirect_slot  - target slot within line
//   halted         - end of program reached, fetch stopped
// Revision : 1.0 - initial release
// ============================================================================
module fetch_align_unit #(
  parameter int HALT_LINES = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [4:0]  line_idx,
  input  logic [63:0] ir_line,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_is_c,
  output logic [5:0]  out_pc,
  input  logic        redirect_valid,
  input  logic [4:0]  redirect_line,
  input  logic        redirect_slot,
  output logic        halted
);

  localparam logic [3:0] HALT_CNT = 4'(HALT_LINES);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_ISSUE = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t      state;
  logic [63:0] line_buf;
  logic [4:0]  cur_line;
  logic        ptr;
  logic        start_slot;
  logic        line_had_instr;
  logic [3:0]  empty_cnt;

  logic [31:0] slot_word;
  logic        slot_full;
  logic        slot_is_c;
  logic        issue_valid;
  logic        handshake;
  logic        advance;
  logic        line_used;
  logic [3:0]  next_empty;

  // Everything below is decoded from registers only; out_ready and
  // redirect_* never reach the out_* pins combinationally.
  assign slot_word   = ptr ? line_buf[31:0] : line_buf[63:32];
  assign slot_full   = (slot_word != 32'd0);
  assign slot_is_c   = (slot_word[1:0] != 2'b11);
  assign issue_valid = (state == S_ISSUE) && slot_full;
  assign handshake   = issue_valid && out_ready;
  // An empty slot is skipped immediately; a full one waits for decode.
  assign advance     = (state == S_ISSUE) && (!slot_full || out_ready);
  assign line_used   = line_had_instr || handshake;
  assign next_empty  = line_used ? 4'd0 : empty_cnt + 4'd1;

  // Payload is forced to zero whenever nothing is presented, so idle
  // cycles show a clean, deterministic bus.
  assign out_valid = issue_valid;
  assign out_is_c  = issue_valid && slot_is_c;
  assign out_instr = !issue_valid ? 32'd0 :
                     slot_is_c    ? {16'd0, slot_word[15:0]} : slot_word;
  assign out_pc    = issue_valid ? {cur_line, ptr} : 6'd0;
  assign halted    = (state == S_HALT);
  assign line_idx  = cur_line;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_FETCH;
      line_buf       <= 64'd0;
      cur_line       <= 5'd0;
      ptr            <= 1'b0;
      start_slot     <= 1'b0;
      line_had_instr <= 1'b0;
      empty_cnt      <= 4'd0;
    end else if (redirect_valid) begin
      // A handshake in this same cycle still completes on the decode side;
      // squashing it is decode's responsibility.
      cur_line   <= redirect_line;
      start_slot <= redirect_slot;
      empty_cnt  <= 4'd0;
      state      <= S_FETCH;
    end else begin
      case (state)
        S_FETCH: begin
          line_buf       <= ir_line;
          ptr            <= start_slot;
          line_had_instr <= 1'b0;
          state          <= S_ISSUE;
        end
        S_ISSUE: begin
          if (advance) begin
            if (handshake) begin
              line_had_instr <= 1'b1;
            end
            if (!ptr) begin
              ptr <= 1'b1;
            end else begin
              // End of line: a line entered at slot 1 whose slot 1 is empty
              // still counts as an empty line.
              empty_cnt <= next_empty;
              if (next_empty == HALT_CNT) begin
                state <= S_HALT;
              end else begin
                cur_line   <= cur_line + 5'd1;
                start_slot <= 1'b0;
                state      <= S_FETCH;
              end
            end
          end
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state <= S_FETCH;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_align_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_align_unit
// Purpose  : Self-checking bench for fetch_align_unit. A cycle-by-cycle
//            vector table drives reset/ready/redirect and holds the expected
//            outputs for each cycle; a short hand-written sequence follows for
//            redirect latency and stall freezing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_align_unit;

  logic        clk;
  logic        reset;
  logic [4:0]  line_idx;
  logic [63:0] ir_line;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_is_c;
  logic [5:0]  out_pc;
  logic        redirect_valid;
  logic [4:0]  redirect_line;
  logic        redirect_slot;
  logic        halted;

  int checks;
  int errors;

  logic [63:0] mem [32];

  fetch_align_unit #(.HALT_LINES(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .line_idx       (line_idx),
    .ir_line        (ir_line),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_is_c       (out_is_c),
    .out_pc         (out_pc),
    .redirect_valid (redirect_valid),
    .redirect_line  (redirect_line),
    .redirect_slot  (redirect_slot),
    .halted         (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model: combinational read of the requested line.
  always_comb ir_line = mem[line_idx];

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        rv;
    logic [4:0]  rl;
    logic        rs;
    logic        ov;
    logic [31:0] oi;
    logic        oc;
    logic [5:0]  op;
    logic        oh;
    logic [4:0]  ol;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t full(input logic rst, input logic rdy, input logic rv,
                                input logic [4:0] rl, input logic rs,
                                input logic ov, input logic [31:0] oi,
                                input logic oc, input logic [5:0] op,
                                input logic oh, input logic [4:0] ol);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.rv = rv; v.rl = rl; v.rs = rs;
    v.ov = ov; v.oi = oi; v.oc = oc; v.op = op; v.oh = oh; v.ol = ol;
    return v;
  endfunction

  function automatic vec_t idle(input logic rdy, input logic [4:0] li, input logic h);
    return full(1'b0, rdy, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 1'b0, 6'd0, h, li);
  endfunction

  function automatic vec_t ins(input logic rdy, input logic [4:0] li,
                               input logic [31:0] oi, input logic oc,
                               input logic [5:0] op);
    return full(1'b0, rdy, 1'b0, 5'd0, 1'b0, 1'b1, oi, oc, op, 1'b0, li);
  endfunction

  task automatic chk(input string name, input int row,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic chk_row(input int row, input vec_t v);
    chk("out_valid", row, 32'(out_valid), 32'(v.ov));
    chk("out_instr", row, out_instr,      v.oi);
    chk("out_is_c",  row, 32'(out_is_c),  32'(v.oc));
    chk("out_pc",    row, 32'(out_pc),    32'(v.op));
    chk("halted",    row, 32'(halted),    32'(v.oh));
    chk("line_idx",  row, 32'(line_idx),  32'(v.ol));
  endtask

  initial begin
    int cycles;

    checks = 0;
    errors = 0;
    for (int i = 0; i < 32; i++) mem[i] = 64'd0;
    mem[0]  = {32'h0000_0000, 32'h0000_5F85};
    mem[1]  = {32'h0000_0000, 32'h0000_8A06};
    mem[2]  = {32'h0000_4501, 32'h0050_0093};
    mem[6]  = {32'h41C0_D093, 32'h0031_0133};
    mem[7]  = {32'hABCD_4505, 32'h0000_0000};
    mem[31] = {32'h0010_0073, 32'h0000_0002};

    // Reset state, then release: FETCH line 0.
    vecs.push_back(full(1, 1, 0, 0, 0, 0, 32'd0, 0, 0, 0, 0));
    vecs.push_back(idle(1, 0, 0));                                 // FETCH 0
    vecs.push_back(idle(1, 0, 0));                                 // slot0 empty
    vecs.push_back(ins (1, 0, 32'h0000_5F85, 1, 1));
    vecs.push_back(idle(1, 1, 0));                                 // FETCH 1
    vecs.push_back(idle(1, 1, 0));
    vecs.push_back(ins (1, 1, 32'h0000_8A06, 1, 3));
    vecs.push_back(idle(1, 2, 0));                                 // FETCH 2
    vecs.push_back(ins (1, 2, 32'h0000_4501, 1, 4));
    // Redirect to line 6 while pc 5 is stalled.
    vecs.push_back(full(0, 0, 1, 6, 0, 1, 32'h0050_0093, 0, 5, 0, 2));
    vecs.push_back(idle(0, 6, 0));                                 // FETCH 6
    for (int k = 0; k < 5; k++)
      vecs.push_back(ins(0, 6, 32'h41C0_D093, 0, 12));             // stalled
    vecs.push_back(ins (1, 6, 32'h41C0_D093, 0, 12));
    vecs.push_back(ins (1, 6, 32'h0031_0133, 0, 13));
    vecs.push_back(idle(1, 7, 0));                                 // FETCH 7
    vecs.push_back(ins (1, 7, 32'h0000_4505, 1, 14));              // upper half dropped
    // Empty slot 1 of line 7, redirect to the empty lines 12/13.
    vecs.push_back(full(0, 1, 1, 12, 0, 0, 32'd0, 0, 0, 0, 7));
    vecs.push_back(idle(1, 12, 0));
    vecs.push_back(idle(1, 12, 0));
    vecs.push_back(idle(1, 12, 0));
    vecs.push_back(idle(1, 13, 0));
    vecs.push_back(idle(1, 13, 0));
    vecs.push_back(idle(1, 13, 0));                                // slot1 of 13
    vecs.push_back(idle(1, 13, 1));                                // halted
    vecs.push_back(full(0, 1, 1, 1, 1, 0, 32'd0, 0, 0, 1, 13));    // redirect out
    vecs.push_back(idle(1, 1, 0));                                 // FETCH 1
    vecs.push_back(ins (1, 1, 32'h0000_8A06, 1, 3));
    vecs.push_back(idle(1, 2, 0));
    vecs.push_back(ins (1, 2, 32'h0000_4501, 1, 4));
    // Handshake and redirect in the same cycle.
    vecs.push_back(full(0, 1, 1, 31, 0, 1, 32'h0050_0093, 0, 5, 0, 2));
    vecs.push_back(idle(1, 31, 0));                                // FETCH 31
    vecs.push_back(ins (1, 31, 32'h0010_0073, 0, 62));
    vecs.push_back(ins (1, 31, 32'h0000_0002, 1, 63));
    vecs.push_back(idle(1, 0, 0));                                 // wrapped to 0
    vecs.push_back(idle(1, 0, 0));
    // Reset asserted mid-ISSUE with a pending instruction.
    vecs.push_back(full(1, 0, 0, 0, 0, 1, 32'h0000_5F85, 1, 1, 0, 0));
    vecs.push_back(idle(1, 0, 0));                                 // reset state / FETCH
    vecs.push_back(idle(1, 0, 0));
    vecs.push_back(ins (1, 0, 32'h0000_5F85, 1, 1));

    reset          = 1'b1;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_line  = 5'd0;
    redirect_slot  = 1'b0;
    @(posedge clk);
    @(negedge clk);

    // Inputs are applied at the falling edge; outputs checked there reflect
    // the state after the previous rising edge.
    for (int r = 0; r < vecs.size(); r++) begin
      reset          = vecs[r].rst;
      out_ready      = vecs[r].rdy;
      redirect_valid = vecs[r].rv;
      redirect_line  = vecs[r].rl;
      redirect_slot  = vecs[r].rs;
      chk_row(r, vecs[r]);
      @(negedge clk);
    end

    // Redirect into slot 1 of line 6: first valid two cycles after the pulse.
    reset          = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_line  = 5'd6;
    redirect_slot  = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0;
    cycles = 1;
    while (!out_valid && cycles < 8) begin
      @(negedge clk);
      cycles++;
    end
    chk("redir_latency", 100, 32'(cycles), 32'd2);
    chk("redir_pc",      100, 32'(out_pc), 32'd13);
    chk("redir_instr",   100, out_instr,   32'h0031_0133);

    // Stall freeze: nothing moves while decode is not ready.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_valid", 101 + k, 32'(out_valid), 32'd1);
      chk("stall_pc",    101 + k, 32'(out_pc),    32'd13);
      chk("stall_idx",   101 + k, 32'(line_idx),  32'd6);
    end

    // Accept it: line 6 had an instruction, so fetch proceeds to line 7.
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_idx",   104, 32'(line_idx),  32'd7);
    chk("post_valid", 104, 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_align_unit.md
# fetch_align_unit

Fetch/align stage directly downstream of the instruction memory. It drives the 5-bit line index into the instruction memory and captures the returned 64-bit line. Each line holds two 32-bit slots, and each slot carries either a 32-bit instruction or a 16-bit compressed instruction. The unit splits the line into slots, drops empty slots, and presents one instruction per handshake to decode, with redirect (branch/jump) and end-of-program halt support.

## Interface
Parameters:
- HALT_LINES, 2, number of consecutive all-empty lines after which the unit halts (1..15).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- line_idx  output  5  line index to instruction memory (PC_Sel).
- ir_line  input  64  line from instruction memory. Slot 0 = [63:32], slot 1 = [31:0]. Combinationally valid in the same cycle as line_idx.
- out_valid  output  1  instruction present on out_*.
- out_ready  input  1  decode accepts when out_valid && out_ready.
- out_instr  output  32  instruction; compressed forms zero-extended, [31:16]=0.
- out_is_c  output  1  1 = compressed (slot[1:0] != 2'b11).
- out_pc  output  6  {line, slot} of presented instruction.
- redirect_valid  input  1  restart fetch at target.
- redirect_line  input  5  target line.
- redirect_slot  input  1  target slot within line.
- halted  output  1  end of program reached; fetch stopped.

## Operation
- States: FETCH, ISSUE, HALT.
- Registers:
  - line buffer (64b)
  - cur_line (5b; drives line_idx)
  - ptr (1b)
  - start_slot (1b)
  - line_had_instr (1b)
  - empty_cnt (4b)
- Reset:
  - state=FETCH, cur_line=0, ptr=0, start_slot=0, empty_cnt=0, line buffer=0.
  - out_valid=0, out_instr=0, out_is_c=0, out_pc=0, halted=0, line_idx=0.
- FETCH (one cycle):
  - Capture ir_line into the buffer; set ptr=start_slot; clear line_had_instr; go to ISSUE.
  - out_valid=0.
- ISSUE: current slot word w = buffer slot ptr.
  - Empty slot (w==0): out_valid=0. The slot is skipped in one cycle with no handshake.
  - Non-empty slot: out_valid=1.
    - out_is_c=(w[1:0]!=2'b11).
    - out_instr = compressed ? {16'b0,w[15:0]} : w. Upper 16 bits of a compressed slot are discarded.
    - Hold all out_* stable until handshake. On handshake, set line_had_instr and advance.
  - Advance from ptr=0: ptr=1.
  - Advance from ptr=1 (end of line):
    - Update empty counter: if the line had no instruction, empty_cnt++; otherwise empty_cnt=0.
    - If the new empty_cnt==HALT_LINES, go to HALT.
    - Otherwise cur_line=cur_line+1 (31 wraps to 0), start_slot=0, go to FETCH.
- HALT:
  - halted=1, out_valid=0, line_idx holds.
  - Only reset or redirect leaves HALT.
- Redirect (any state, highest priority after reset):
  - cur_line=redirect_line, start_slot=redirect_slot, empty_cnt=0, halted=0; next state FETCH.
  - A redirect into slot 1 skips slot 0 of the target line.
  - Empty-line counting still counts a redirected line with empty slot 1 as empty.
- out_* are decoded from registered state only; there is no combinational path from out_ready or redirect_* to out_*.

## Timing
- Sequential line (two 32-bit or compressed instructions, decode always ready): 3 cycles per line (FETCH, slot0, slot1).
- Empty slot costs 1 cycle with out_valid=0.
- Reset release: cycle 0 = FETCH with line_idx=0; cycle 1 = first possible out_valid.
- Redirect at cycle N: out_valid=0 and FETCH of target at N+1; first target instruction valid at N+2.
- Redirect and handshake in the same cycle: the handshake completes (decode owns squash); the next presented instruction is from the target.
- Stall: with out_ready=0, state, line_idx and out_* are frozen indefinitely.
- Reset mid-operation: on the next edge, all registers and outputs return to their reset values, regardless of pending handshake or redirect.
- line_idx changes only on the edge entering FETCH; it is stable throughout ISSUE.

## Test plan
- Reset, then line 0 = {32'h0, 32'h0000_5F85}, line 1 = {32'h0, 32'h0000_8A06}, out_ready=1 -> line 0: one empty cycle, then out_instr=32'h0000_5F85, out_is_c=1, out_pc=6'd1. Line 1: one empty cycle, then out_instr=32'h0000_8A06, out_pc=6'd3.
- Line 6 = {32'h41C0_D093, 32'h0031_0133}, out_ready held 0 for 5 cycles -> out_instr=32'h41C0_D093, out_is_c=0, out_pc=6'd12, stable for all 5 cycles. Then one accept each for 32'h0031_0133, out_pc=6'd13.
- Lines 12 and 13 all zero, HALT_LINES=2 -> out_valid never asserts; halted=1 after the slot-1 cycle of line 13; line_idx stays 13.
- While halted, pulse redirect_valid with line=1, slot=1 -> halted=0 next cycle, line_idx=1. Slot-1 instruction of line 1 presented 2 cycles after the pulse with out_pc=6'd3.
- Redirect asserted while out_valid=1 and out_ready=0 at out_pc=6'd5 -> next cycle out_valid=0 and FETCH of the target; the old instruction is never re-presented.
- Reach line 31 with non-empty slots -> after slot 1, line_idx wraps to 0. Reset asserted mid-ISSUE -> out_valid=0, line_idx=0, out_pc=0 on the next edge.
